// File: rtl/mac_pkg.sv
// Shared types and constants for the mac_pe systolic processing element.
// Saturation bounds are computed at a fixed wide width and sized by the caller.
package mac_pkg;

   typedef enum logic {
      MODE_WS = 1'b0,
      MODE_OS = 1'b1
   } mac_mode_e;

   localparam int DATA_W_DEF = 8;
   localparam int ACC_W_DEF  = 24;
   localparam int SAT_FN_W   = 64;

   function automatic logic [SAT_FN_W-1:0] sat_max(input int width, input bit is_signed);
      logic [SAT_FN_W-1:0] one;
      one = 1;
      return is_signed ? (one << (width - 1)) - one : (one << width) - one;
   endfunction

   // Low `width` bits of the signed result form the most negative value.
   function automatic logic [SAT_FN_W-1:0] sat_min(input int width, input bit is_signed);
      logic [SAT_FN_W-1:0] one;
      one = 1;
      return is_signed ? (one << (width - 1)) : '0;
   endfunction

endpackage

// File: rtl/mac_sat_add.sv
// Saturating accumulate: extends addend and product to ACC_W+1 bits, adds,
// then clamps to the representable accumulator range and flags the clamp.
module mac_sat_add
   import mac_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W  = ACC_W_DEF,
   parameter int SIGNED = 1
) (
   input  logic [ACC_W-1:0]    i_addend,
   input  logic [2*DATA_W-1:0] i_prod,
   output logic [ACC_W-1:0]    o_sum,
   output logic                o_ovf
);

   localparam int EXT_W = ACC_W + 1 - 2*DATA_W;
   localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(ACC_W, SIGNED != 0));
   localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(ACC_W, SIGNED != 0));

   logic [ACC_W:0] w_addend_ext;
   logic [ACC_W:0] w_prod_ext;
   logic [ACC_W:0] w_sum;

   assign w_sum = w_addend_ext + w_prod_ext;

   generate
      if (SIGNED != 0) begin : g_signed
         assign w_addend_ext = {i_addend[ACC_W-1], i_addend};
         assign w_prod_ext   = {{EXT_W{i_prod[2*DATA_W-1]}}, i_prod};
         // The extra top bit disagrees with the accumulator sign bit only on overflow.
         assign o_ovf        = w_sum[ACC_W] ^ w_sum[ACC_W-1];
         assign o_sum        = o_ovf ? (w_sum[ACC_W] ? SAT_MIN : SAT_MAX) : w_sum[ACC_W-1:0];
      end else begin : g_unsigned
         assign w_addend_ext = {1'b0, i_addend};
         assign w_prod_ext   = {{EXT_W{1'b0}}, i_prod};
         assign o_ovf        = w_sum[ACC_W];
         assign o_sum        = o_ovf ? SAT_MAX : w_sum[ACC_W-1:0];
      end
   endgenerate

endmodule

// File: rtl/mac_pe.sv
// Systolic-array PE with weight-stationary column accumulation and
// output-stationary local accumulation with drain; all outputs registered.
module mac_pe
   import mac_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W  = ACC_W_DEF,
   parameter int SIGNED = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mode,
   input  logic              wt_load,
   input  logic [DATA_W-1:0] wt_in,
   output logic [DATA_W-1:0] wt_out,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   input  logic              data_valid_in,
   output logic              data_valid_out,
   input  logic [ACC_W-1:0]  acc_in,
   output logic [ACC_W-1:0]  acc_out,
   input  logic              acc_valid_in,
   output logic              acc_valid_out,
   input  logic              os_clear,
   input  logic              os_drain,
   output logic              ovf
);

   logic [DATA_W-1:0]   r_w;
   logic [ACC_W-1:0]    r_l;
   logic [DATA_W-1:0]   r_wt_out;
   logic [DATA_W-1:0]   r_data_out;
   logic                r_data_valid_out;
   logic [ACC_W-1:0]    r_acc_out;
   logic                r_acc_valid_out;
   logic                r_ovf;

   logic                w_is_os;
   logic [DATA_W-1:0]   w_mult;
   logic [2*DATA_W-1:0] w_prod;
   logic [ACC_W-1:0]    w_addend;
   logic [ACC_W-1:0]    w_sum;
   logic                w_sat;

   assign w_is_os = (mac_mode_e'(mode) == MODE_OS);
   assign w_mult  = w_is_os ? wt_in : r_w;
   // A clear zeroes the addend so clear-and-accumulate lands P directly in L.
   assign w_addend = w_is_os ? (os_clear ? '0 : r_l) : acc_in;

   generate
      if (SIGNED != 0) begin : g_mul_s
         assign w_prod = $signed({{DATA_W{data_in[DATA_W-1]}}, data_in})
                       * $signed({{DATA_W{w_mult[DATA_W-1]}}, w_mult});
      end else begin : g_mul_u
         assign w_prod = {{DATA_W{1'b0}}, data_in} * {{DATA_W{1'b0}}, w_mult};
      end
   endgenerate

   mac_sat_add #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W),
      .SIGNED (SIGNED)
   ) u_sat_add (
      .i_addend (w_addend),
      .i_prod   (w_prod),
      .o_sum    (w_sum),
      .o_ovf    (w_sat)
   );

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_w              <= '0;
         r_l              <= '0;
         r_wt_out         <= '0;
         r_data_out       <= '0;
         r_data_valid_out <= 1'b0;
         r_acc_out        <= '0;
         r_acc_valid_out  <= 1'b0;
         r_ovf            <= 1'b0;
      end else begin
         r_wt_out         <= wt_in;
         r_data_out       <= data_in;
         r_data_valid_out <= data_valid_in;
         if (!w_is_os) begin
            if (wt_load) r_w <= wt_in;
            if (data_valid_in) begin
               r_acc_out       <= w_sum;
               r_acc_valid_out <= 1'b1;
            end else begin
               r_acc_valid_out <= 1'b0;
            end
            if (data_valid_in && w_sat) r_ovf <= 1'b1;
         end else begin
            if (data_valid_in)  r_l <= w_sum;
            else if (os_clear)  r_l <= '0;
            if (os_drain) begin
               r_acc_out       <= r_l;
               r_acc_valid_out <= 1'b1;
            end else begin
               r_acc_out       <= acc_in;
               r_acc_valid_out <= acc_valid_in;
            end
            if (os_clear)                    r_ovf <= data_valid_in && w_sat;
            else if (data_valid_in && w_sat) r_ovf <= 1'b1;
         end
      end
   end

   assign wt_out         = r_wt_out;
   assign data_out       = r_data_out;
   assign data_valid_out = r_data_valid_out;
   assign acc_out        = r_acc_out;
   assign acc_valid_out  = r_acc_valid_out;
   assign ovf            = r_ovf;

endmodule
